// File: rtl/btb_assoc_predictor.sv
// Set-associative branch target buffer with per-entry saturating direction counters,
// tree-PLRU replacement and a post-reset/flush invalidation sweep.

module btb_way_match #(
    parameter int TAG_W = 10
) (
    input  logic             valid,
    input  logic [TAG_W-1:0] tag,
    input  logic [TAG_W-1:0] cmp_tag,
    output logic             match
);
    assign match = valid && (tag == cmp_tag);
endmodule

module btb_assoc_predictor #(
    parameter int WAYS     = 4,
    parameter int SETS     = 32,
    parameter int CTR_BITS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] lookup_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [15:0] pred_target,
    input  logic        update_valid,
    input  logic [15:0] update_pc,
    input  logic        update_taken,
    input  logic [15:0] update_target,
    input  logic        flush,
    output logic        busy
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 15 - IDX_W;
    localparam int LVL   = $clog2(WAYS);
    localparam logic [CTR_BITS-1:0] CTR_WT = CTR_BITS'(1) << (CTR_BITS - 1);

    typedef enum logic {SWEEP, IDLE} state_t;

    state_t           state_q, state_n;
    logic [IDX_W-1:0] sweep_idx, sweep_idx_n;

    logic [SETS-1:0][WAYS-1:0]               valid_q;
    logic [SETS-1:0][WAYS-1:0][TAG_W-1:0]    tag_q;
    logic [SETS-1:0][WAYS-1:0][15:0]         target_q;
    logic [SETS-1:0][WAYS-1:0][CTR_BITS-1:0] ctr_q;
    // Heap-ordered tree: node 1 is the root, children of n are 2n and 2n+1; bit 0 is unused.
    logic [SETS-1:0][WAYS-1:0]               plru_q;

    logic unused_pc_lsb;
    assign unused_pc_lsb = lookup_pc[0] ^ update_pc[0];

    function automatic logic [LVL-1:0] plru_victim(input logic [WAYS-1:0] p);
        logic [LVL:0] node;
        node = (LVL+1)'(1);
        for (int l = 0; l < LVL; l++)
            node = {node[LVL-1:0], p[node[LVL-1:0]]};
        return node[LVL-1:0];
    endfunction

    function automatic logic [WAYS-1:0] plru_touch(input logic [WAYS-1:0] p,
                                                   input logic [LVL-1:0] way);
        logic [WAYS-1:0] r;
        logic [LVL:0]    node;
        r    = p;
        node = {1'b1, way};
        for (int l = 0; l < LVL; l++) begin
            r[node[LVL:1]] = ~node[0];
            node = node >> 1;
        end
        return r;
    endfunction

    // FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SWEEP;
            sweep_idx <= '0;
        end else begin
            state_q   <= state_n;
            sweep_idx <= sweep_idx_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        sweep_idx_n = sweep_idx;
        busy        = (state_q == SWEEP);
        case (state_q)
            SWEEP: begin
                if (flush) begin
                    sweep_idx_n = '0;
                end else if (sweep_idx == IDX_W'(SETS - 1)) begin
                    state_n     = IDLE;
                    sweep_idx_n = '0;
                end else begin
                    sweep_idx_n = sweep_idx + 1'b1;
                end
            end
            IDLE: begin
                if (flush) begin
                    state_n     = SWEEP;
                    sweep_idx_n = '0;
                end
            end
            default: state_n = SWEEP;
        endcase
    end

    // Tag match per way for both ports
    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic [WAYS-1:0]  lk_match, up_match;

    assign lk_idx = lookup_pc[IDX_W:1];
    assign lk_tag = lookup_pc[15:IDX_W+1];
    assign up_idx = update_pc[IDX_W:1];
    assign up_tag = update_pc[15:IDX_W+1];

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        btb_way_match #(.TAG_W(TAG_W)) u_lk (
            .valid(valid_q[lk_idx][w]), .tag(tag_q[lk_idx][w]),
            .cmp_tag(lk_tag), .match(lk_match[w])
        );
        btb_way_match #(.TAG_W(TAG_W)) u_up (
            .valid(valid_q[up_idx][w]), .tag(tag_q[up_idx][w]),
            .cmp_tag(up_tag), .match(up_match[w])
        );
    end

    logic           lk_hit, up_hit, inv_any;
    logic [LVL-1:0] lk_way, up_way, inv_way, alloc_way;

    // Descending scan so the lowest matching / invalid way wins.
    always_comb begin
        lk_hit  = 1'b0;
        lk_way  = '0;
        up_hit  = 1'b0;
        up_way  = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (lk_match[w]) begin
                lk_hit = 1'b1;
                lk_way = LVL'(w);
            end
            if (up_match[w]) begin
                up_hit = 1'b1;
                up_way = LVL'(w);
            end
            if (!valid_q[up_idx][w]) begin
                inv_any = 1'b1;
                inv_way = LVL'(w);
            end
        end
        alloc_way = inv_any ? inv_way : plru_victim(plru_q[up_idx]);
    end

    logic [CTR_BITS-1:0] ctr_cur, ctr_nxt;
    assign ctr_cur = ctr_q[up_idx][up_way];

    always_comb begin
        ctr_nxt = ctr_cur;
        if (update_taken && ctr_cur != '1)
            ctr_nxt = ctr_cur + 1'b1;
        else if (!update_taken && ctr_cur != '0)
            ctr_nxt = ctr_cur - 1'b1;
    end

    logic sweep_clr, upd_en;
    assign sweep_clr = (state_q == SWEEP) && !flush;
    assign upd_en    = update_valid && (state_q == IDLE) && !flush;

    // Table state; valid and PLRU are cleared only by the sweep.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (sweep_clr) begin
                valid_q[sweep_idx] <= '0;
                plru_q[sweep_idx]  <= '0;
            end else if (upd_en) begin
                if (up_hit) begin
                    ctr_q[up_idx][up_way] <= ctr_nxt;
                    if (update_taken)
                        target_q[up_idx][up_way] <= update_target;
                    plru_q[up_idx] <= plru_touch(plru_q[up_idx], up_way);
                end else if (update_taken) begin
                    valid_q[up_idx][alloc_way]  <= 1'b1;
                    tag_q[up_idx][alloc_way]    <= up_tag;
                    target_q[up_idx][alloc_way] <= update_target;
                    ctr_q[up_idx][alloc_way]    <= CTR_WT;
                    plru_q[up_idx]              <= plru_touch(plru_q[up_idx], alloc_way);
                end
            end
        end
    end

    // Prediction registers read pre-update table contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= 16'h0000;
        end else if (busy || !lk_hit) begin
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
        end else begin
            pred_hit    <= 1'b1;
            pred_taken  <= ctr_q[lk_idx][lk_way][CTR_BITS-1];
            pred_target <= target_q[lk_idx][lk_way];
        end
    end
endmodule

// File: tb/tb_btb_assoc_predictor.sv
// Directed bench for btb_assoc_predictor: vector table of update/lookup pairs plus
// hand sequences for reset sweep, flush restart and same-cycle read-before-write.

module tb_btb_assoc_predictor;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] lookup_pc;
    logic        pred_hit, pred_taken;
    logic [15:0] pred_target;
    logic        update_valid;
    logic [15:0] update_pc;
    logic        update_taken;
    logic [15:0] update_target;
    logic        flush;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    btb_assoc_predictor #(.WAYS(4), .SETS(32), .CTR_BITS(2)) dut (
        .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .update_valid(update_valid), .update_pc(update_pc),
        .update_taken(update_taken), .update_target(update_target),
        .flush(flush), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        upd;
        logic [15:0] upc;
        logic        ut;
        logic [15:0] utgt;
        logic [15:0] lpc;
        logic        eh;
        logic        et;
        logic [15:0] etg;
    } vec_t;

    vec_t vecs [22];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One update cycle (lookup parked on an unused pc), then one lookup cycle, then check.
    task automatic apply_vec(input int i);
        vec_t v;
        v = vecs[i];
        update_valid  = v.upd;
        update_pc     = v.upc;
        update_taken  = v.ut;
        update_target = v.utgt;
        lookup_pc     = 16'hFFFE;
        @(posedge clk); #1;
        update_valid = 1'b0;
        lookup_pc    = v.lpc;
        @(posedge clk); #1;
        check($sformatf("v%0d_hit", i), 16'(pred_hit), 16'(v.eh));
        check($sformatf("v%0d_taken", i), 16'(pred_taken), 16'(v.et));
        check($sformatf("v%0d_target", i), pred_target, v.etg);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) apply_vec(i);
    endtask

    initial begin
        int cnt;
        //              upd   upc       ut    utgt      lpc       eh    et    etg
        vecs[0]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h1000, 1'b0, 1'b0, 16'h0000};
        vecs[1]  = '{1'b1, 16'h3004, 1'b1, 16'h3100, 16'h3004, 1'b1, 1'b1, 16'h3100};
        vecs[2]  = '{1'b1, 16'h3004, 1'b0, 16'h1111, 16'h3004, 1'b1, 1'b0, 16'h3100};
        vecs[3]  = '{1'b1, 16'h3004, 1'b0, 16'h1111, 16'h3004, 1'b1, 1'b0, 16'h3100};
        vecs[4]  = '{1'b1, 16'h3004, 1'b0, 16'h1111, 16'h3004, 1'b1, 1'b0, 16'h3100};
        vecs[5]  = '{1'b1, 16'h3004, 1'b1, 16'h3100, 16'h3004, 1'b1, 1'b0, 16'h3100};
        vecs[6]  = '{1'b1, 16'h3004, 1'b1, 16'h3100, 16'h3004, 1'b1, 1'b1, 16'h3100};
        vecs[7]  = '{1'b1, 16'h3004, 1'b1, 16'h3200, 16'h3004, 1'b1, 1'b1, 16'h3200};
        vecs[8]  = '{1'b1, 16'h3004, 1'b1, 16'h3100, 16'h3004, 1'b1, 1'b1, 16'h3100};
        vecs[9]  = '{1'b1, 16'h3004, 1'b0, 16'h1111, 16'h3004, 1'b1, 1'b1, 16'h3100};
        vecs[10] = '{1'b1, 16'h2008, 1'b0, 16'h2222, 16'h2008, 1'b0, 1'b0, 16'h3100};
        // after flush
        vecs[11] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h3004, 1'b0, 1'b0, 16'h3100};
        vecs[12] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h5000, 1'b0, 1'b0, 16'h3100};
        // set 2 conflict
        vecs[13] = '{1'b1, 16'h0004, 1'b1, 16'h0A00, 16'h0004, 1'b1, 1'b1, 16'h0A00};
        vecs[14] = '{1'b1, 16'h0044, 1'b1, 16'h0A44, 16'h0044, 1'b1, 1'b1, 16'h0A44};
        vecs[15] = '{1'b1, 16'h0084, 1'b1, 16'h0A84, 16'h0084, 1'b1, 1'b1, 16'h0A84};
        vecs[16] = '{1'b1, 16'h00C4, 1'b1, 16'h0AC4, 16'h00C4, 1'b1, 1'b1, 16'h0AC4};
        vecs[17] = '{1'b1, 16'h0104, 1'b1, 16'h0B04, 16'h0104, 1'b1, 1'b1, 16'h0B04};
        vecs[18] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0004, 1'b0, 1'b0, 16'h0B04};
        vecs[19] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0044, 1'b1, 1'b1, 16'h0A44};
        vecs[20] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0084, 1'b1, 1'b1, 16'h0A84};
        vecs[21] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h00C4, 1'b1, 1'b1, 16'h0AC4};

        reset = 1'b1; flush = 1'b0; update_valid = 1'b0; update_pc = '0;
        update_taken = 1'b0; update_target = '0; lookup_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hit", 16'(pred_hit), 16'd0);
        check("rst_taken", 16'(pred_taken), 16'd0);
        check("rst_target", pred_target, 16'h0000);
        check("rst_busy", 16'(busy), 16'd1);
        reset = 1'b0;

        cnt = 0;
        while (busy && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("reset_sweep_len", 16'(cnt), 16'd32);

        run_vecs(0, 10);

        // Flush with a live entry; lookups during the sweep must miss.
        lookup_pc = 16'h3004;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 16'(busy), 16'd1);
        check("pre_sweep_hit", 16'(pred_hit), 16'd1);
        cnt = 0;
        while (busy && cnt < 200) begin
            update_valid  = (cnt == 10);
            update_pc     = 16'h5000;
            update_taken  = 1'b1;
            update_target = 16'h5500;
            flush         = (cnt == 20);
            @(posedge clk); #1;
            cnt++;
            if (cnt == 1) check("busy_lookup_hit", 16'(pred_hit), 16'd0);
        end
        update_valid = 1'b0;
        flush        = 1'b0;
        check("flush_sweep_len", 16'(cnt), 16'd53);

        run_vecs(11, 21);

        // Same-cycle update and lookup of a new pc: lookup sees pre-update table.
        update_valid  = 1'b1;
        update_pc     = 16'h4000;
        update_taken  = 1'b1;
        update_target = 16'h4400;
        lookup_pc     = 16'h4000;
        @(posedge clk); #1;
        update_valid = 1'b0;
        check("rbw_hit", 16'(pred_hit), 16'd0);
        check("rbw_target", pred_target, 16'h0AC4);
        @(posedge clk); #1;
        check("rbw_next_hit", 16'(pred_hit), 16'd1);
        check("rbw_next_taken", 16'(pred_taken), 16'd1);
        check("rbw_next_target", pred_target, 16'h4400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
